chr_gen_osd_scan: RTL

Parametrised NTSC raster and OSD scan generator clocked at 4×fsc. It produces composite sync, blanking and burst gates, and a character window with per-axis magnification, position delay and wrap-around scroll. For each window pixel it emits a VRAM read address and font row/column. It replaces the fixed-geometry timing inside the character-generator test top and feeds the VRAM/font ROM/FUCHI pipeline.

---
 rtl/chr_gen_osd_scan.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/chr_gen_osd_scan.sv
// chr_gen_osd_scan: NTSC raster timing plus OSD character-window scan generator at 4xfsc.
// Rev 1.0 - initial release.
`default_nettype none

module chr_gen_osd_scan #(
  parameter int C_H_TOTAL  = 910,
  parameter int C_V_TOTAL  = 262,
  parameter int C_HSYNC_W  = 67,
  parameter int C_HBLK_W   = 150,
  parameter int C_BURST_ST = 76,
  parameter int C_BURST_W  = 36,
  parameter int C_VSYNC_L  = 3,
  parameter int C_VBLK_L   = 20,
  parameter int C_WIN_COLS = 32,
  parameter int C_WIN_ROWS = 24
) (
  input  logic        NFSC_CK_i,
  input  logic        XSYS_R_i,
  input  logic [11:0] BUS_H_DLYs_i,
  input  logic [10:0] BUS_V_DLYs_i,
  input  logic [2:0]  BUS_H_MAGs_i,
  input  logic [2:0]  BUS_V_MAGs_i,
  input  logic [7:0]  BUS_H_SCROLLs_i,
  input  logic [7:0]  BUS_V_SCROLLs_i,
  input  logic        BUS_OSD_OFF_i,
  output logic        XSYNC_o,
  output logic        BLANK_o,
  output logic        BURST_o,
  output logic        WIN_o,
  output logic        VRAM_RE_o,
  output logic [9:0]  VRAM_RAs_o,
  output logic [2:0]  FONT_ROWs_o,
  output logic [2:0]  FONT_COLs_o,
  output logic        FRAME_o
);

  localparam int c_hw      = (C_H_TOTAL > 1) ? $clog2(C_H_TOTAL) : 1;
  localparam int c_vw      = (C_V_TOTAL > 1) ? $clog2(C_V_TOTAL) : 1;
  localparam int c_cols_px = C_WIN_COLS * 8;
  localparam int c_rows_px = C_WIN_ROWS * 8;

  typedef logic [c_hw-1:0] h_t;
  typedef logic [c_vw-1:0] v_t;

  h_t          r_h;
  v_t          r_v;
  logic [11:0] r_hdly;
  logic [10:0] r_vdly;
  logic [2:0]  r_hmag;
  logic [2:0]  r_vmag;
  logic [7:0]  r_hscr;
  logic [7:0]  r_vscr;
  logic [7:0]  r_x;
  logic [2:0]  r_hsub;
  logic [7:0]  r_y;
  logic [2:0]  r_vsub;

  logic [13:0] w_h;
  logic [13:0] w_v;
  logic [13:0] w_hs;
  logic [13:0] w_he;
  logic [13:0] w_vs;
  logic [13:0] w_ve;
  logic        w_h_in;
  logic        w_v_in;
  logic        w_hstart;
  logic        w_vstart;
  logic        w_hlast;
  logic        w_vlast;
  logic [7:0]  w_x;
  logic [2:0]  w_hsub;
  logic [7:0]  w_y;
  logic [2:0]  w_vsub;
  logic [7:0]  w_sx;
  logic [7:0]  w_sy;
  logic        w_win;
  logic        w_re;
  logic        w_vsync_line;
  logic        w_sync;
  logic        w_blank;
  logic        w_burst;

  assign w_h = 14'(r_h);
  assign w_v = 14'(r_v);

  // Window bounds use 14-bit arithmetic so large delay/magnification never wraps.
  assign w_hs = 14'(C_HBLK_W) + 14'(r_hdly);
  assign w_he = w_hs + 14'(c_cols_px) * (14'(r_hmag) + 14'd1);
  assign w_vs = 14'(C_VBLK_L) + 14'(r_vdly);
  assign w_ve = w_vs + 14'(c_rows_px) * (14'(r_vmag) + 14'd1);

  assign w_h_in   = (w_h >= w_hs) && (w_h < w_he);
  assign w_v_in   = (w_v >= w_vs) && (w_v < w_ve);
  assign w_hstart = (w_h == w_hs);
  assign w_vstart = (w_v == w_vs);
  assign w_hlast  = (r_h == h_t'(C_H_TOTAL - 1));
  assign w_vlast  = (r_v == v_t'(C_V_TOTAL - 1));

  // Pixel state registers hold the position of the *current* clock; the start
  // of a window line/field overrides them with zero.
  assign w_x    = w_hstart ? 8'd0 : r_x;
  assign w_hsub = w_hstart ? 3'd0 : r_hsub;
  assign w_y    = w_vstart ? 8'd0 : r_y;
  assign w_vsub = w_vstart ? 3'd0 : r_vsub;

  assign w_sx = w_x + r_hscr;
  assign w_sy = w_y + r_vscr;

  assign w_win = w_h_in && w_v_in && !BUS_OSD_OFF_i;
  assign w_re  = w_win && (((w_sx[2:0] == 3'd0) && (w_hsub == 3'd0)) || w_hstart);

  assign w_vsync_line = (w_v < 14'(C_VSYNC_L));
  assign w_sync  = w_vsync_line ? (w_h < 14'(C_H_TOTAL - C_HSYNC_W))
                                : (w_h < 14'(C_HSYNC_W));
  assign w_blank = (w_h < 14'(C_HBLK_W)) || (w_v < 14'(C_VBLK_L));
  assign w_burst = (w_h >= 14'(C_BURST_ST)) && (w_h < 14'(C_BURST_ST + C_BURST_W))
                   && !w_vsync_line;

  always_ff @(posedge NFSC_CK_i) begin
    if (!XSYS_R_i) begin
      r_h    <= '0;
      r_v    <= '0;
      r_hdly <= '0;
      r_vdly <= '0;
      r_hmag <= '0;
      r_vmag <= '0;
      r_hscr <= '0;
      r_vscr <= '0;
      r_x    <= '0;
      r_hsub <= '0;
      r_y    <= '0;
      r_vsub <= '0;
    end else begin
      if (w_hlast) begin
        r_h <= '0;
        r_v <= w_vlast ? '0 : r_v + v_t'(1);
      end else begin
        r_h <= r_h + h_t'(1);
      end

      // Geometry only changes on field boundaries to avoid tearing.
      if ((r_h == '0) && (r_v == '0)) begin
        r_hdly <= BUS_H_DLYs_i;
        r_vdly <= BUS_V_DLYs_i;
        r_hmag <= BUS_H_MAGs_i;
        r_vmag <= BUS_V_MAGs_i;
        r_hscr <= BUS_H_SCROLLs_i;
        r_vscr <= BUS_V_SCROLLs_i;
      end

      if (w_h_in) begin
        if (w_hsub == r_hmag) begin
          r_hsub <= '0;
          r_x    <= w_x + 8'd1;
        end else begin
          r_hsub <= w_hsub + 3'd1;
          r_x    <= w_x;
        end
      end

      if (w_hlast && w_v_in) begin
        if (w_vsub == r_vmag) begin
          r_vsub <= '0;
          r_y    <= w_y + 8'd1;
        end else begin
          r_vsub <= w_vsub + 3'd1;
          r_y    <= w_y;
        end
      end
    end
  end

  always_ff @(posedge NFSC_CK_i) begin
    if (!XSYS_R_i) begin
      XSYNC_o     <= 1'b1;
      BLANK_o     <= 1'b1;
      BURST_o     <= 1'b0;
      WIN_o       <= 1'b0;
      VRAM_RE_o   <= 1'b0;
      VRAM_RAs_o  <= '0;
      FONT_ROWs_o <= '0;
      FONT_COLs_o <= '0;
      FRAME_o     <= 1'b0;
    end else begin
      XSYNC_o     <= !w_sync;
      BLANK_o     <= w_blank;
      BURST_o     <= w_burst;
      WIN_o       <= w_win;
      VRAM_RE_o   <= w_re;
      VRAM_RAs_o  <= w_win ? {w_sy[7:3], w_sx[7:3]} : 10'd0;
      FONT_ROWs_o <= w_win ? w_sy[2:0] : 3'd0;
      FONT_COLs_o <= w_win ? w_sx[2:0] : 3'd0;
      FRAME_o     <= (r_h == '0) && (r_v == '0);
    end
  end

endmodule

`default_nettype wire
